ula_seq: RTL and testbench
==========================

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed element width, two's complement.
REQ-002 SHALL have parameter DIM, default 5: maximum matrix dimension; element (r,c) at bits [DATA_W*(c+DIM*r) +: DATA_W].
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-004 Ports, in order:
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: request an operation; sampled only in IDLE.
- opcode, in, 3: 000 add, 001 sub, 010 matrix multiply, 011 scalar multiply, 100 transpose, 101 negate, 110/111 reserved.
- tamanho, in, 8: active dimension n.
- escalar, in, DATA_W: signed scalar.
- matriz1, in, DIM*DIM*DATA_W: operand A.
- matriz2, in, DIM*DIM*DATA_W: operand B.
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.
- sat, out, 1: saturation occurred in last operation.
- err, out, 1: last opcode was reserved.
- resultado, out, DIM*DIM*DATA_W: result matrix.

Function
REQ-005 SHALL implement states IDLE, COMPUTE and DONE.
REQ-006 IDLE with start=1 SHALL, on that edge:
- latch opcode, tamanho, escalar, matriz1 and matriz2;
- clear index k, the internal sat accumulator and the internal buffer;
- enter COMPUTE with busy=1.
REQ-007 COMPUTE SHALL produce one result element per cycle at index k = 0..DIM*DIM-1 (row-major), write it to an internal buffer, then enter DONE after k=DIM*DIM-1.
REQ-008 DONE SHALL, for exactly one cycle:
- copy the buffer to resultado;
- assert done=1 with busy=0;
- update sat and err;
then return to IDLE.
REQ-009 Latency: done SHALL be high in the cycle following the (DIM*DIM+1)th rising edge after the edge sampling start; for DIM=5 that is edge 26.
REQ-010 start while busy or during DONE SHALL be ignored; input changes after the latch SHALL NOT affect the operation in progress.
REQ-011 Effective n SHALL be tamanho when 1<=tamanho<=DIM, else DIM.
REQ-012 Elements with r>=n or c>=n SHALL be 0.
REQ-013 Element rules for r,c<n:
- add: A+B.
- sub: A-B.
- scalar multiply: A*escalar.
- negate: -A.
- transpose: A(c,r).
- multiply: sum over j<n of A(r,j)*B(j,c).
REQ-014 Intermediates SHALL be full width, with no intermediate truncation:
- DATA_W+1 bits for add and sub.
- 2*DATA_W bits for products.
- 2*DATA_W+clog2(DIM) bits for the multiply accumulation.
REQ-015 Result reduction to DATA_W is per ULA_SEQ_SAT_EN (REQ-021).
REQ-016 Reserved opcode SHALL produce an all-zero result with err=1 and the normal latency.
REQ-017 resultado, sat and err SHALL hold their values until the next DONE.

Reset
REQ-018 rst=1 SHALL, on the next edge and from any state including mid-COMPUTE:
- enter IDLE;
- set busy, done, sat and err to 0;
- set resultado, the buffer and k to 0;
- abandon any operation in progress.
REQ-019 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-020 Macro ULA_SEQ_SAT_EN SHALL select saturating arithmetic.
REQ-021 With ULA_SEQ_SAT_EN defined:
- each result SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
- any clamp SHALL set the sticky sat accumulator, reported at DONE.
REQ-022 With ULA_SEQ_SAT_EN undefined:
- results SHALL keep the low DATA_W bits (wrap-around);
- sat SHALL be constant 0.

Verification (DATA_W=8, DIM=5, macro defined unless stated)
REQ-023 Add, all A=100, B=50, tamanho=5 -> all 25 elements 127, sat=1, err=0, done exactly 26 edges after start.
REQ-024 Multiply, A=identity, B(r,c)=5r+c, tamanho=5 -> resultado=B, sat=0.
REQ-025 Transpose, tamanho=3, A(r,c)=5r+c -> 3x3 block holds 5c+r, remaining 16 elements 0.
REQ-026 Negate, A all -128 -> all 127, sat=1; with macro undefined -> all -128, sat=0.
REQ-027 rst at edge 10 of a sub -> next cycle busy=0, done=0, resultado=0, no done pulse.
REQ-028 start pulsed during busy -> ignored, exactly one done.
REQ-029 Opcode 111 -> all zero, err=1, done at edge 26.

Source files
------------

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq -- sequential matrix ALU.
//
// Purpose: accepts two DIM x DIM signed matrices and computes, one element per
// clock in row-major order, one of: add, sub, matrix multiply, scalar
// multiply, transpose or negate over the active n x n block (elements outside
// the block are zero). The finished matrix is published with a one-cycle
// done pulse and held until the next operation completes.
//
// Configuration macro: ULA_SEQ_SAT_EN
//   defined   -> each result element clamps to the DATA_W signed range and a
//                sticky saturation flag is reported on sat at completion.
//   undefined -> results wrap to the low DATA_W bits; sat is constant 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      operation request, sampled only while idle
//   opcode     000 add, 001 sub, 010 mat mul, 011 scalar mul,
//              100 transpose, 101 negate, 110/111 reserved
//   tamanho    active dimension n (1..DIM, anything else means DIM)
//   escalar    signed scalar for scalar multiply
//   matriz1    operand A, element (r,c) at [DATA_W*(c+DIM*r) +: DATA_W]
//   matriz2    operand B, same layout
//   busy       operation in progress
//   done       one-cycle completion pulse
//   sat        saturation occurred in the last operation
//   err        last opcode was reserved
//   resultado  result matrix, same layout as the operands
// ---------------------------------------------------------------------------
module ula_seq #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 opcode,
  input  logic [7:0]                 tamanho,
  input  logic [DATA_W-1:0]          escalar,
  input  logic [DIM*DIM*DATA_W-1:0]  matriz1,
  input  logic [DIM*DIM*DATA_W-1:0]  matriz2,
  output logic                       busy,
  output logic                       done,
  output logic                       sat,
  output logic                       err,
  output logic [DIM*DIM*DATA_W-1:0]  resultado
);

  localparam int MW    = DIM * DIM * DATA_W;
  localparam int NEL   = DIM * DIM;
  localparam int KW    = (NEL > 1) ? $clog2(NEL) : 1;
  localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int ACC_W = 2 * DATA_W + $clog2(DIM);

  // Clamp bounds of a DATA_W signed value, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [2:0]                op_q, op_d;
  logic [7:0]                n_q, n_d;
  logic signed [DATA_W-1:0]  esc_q, esc_d;
  logic [MW-1:0]             a_q, a_d;
  logic [MW-1:0]             b_q, b_d;
  logic [KW-1:0]             k_q, k_d;
  logic [RW-1:0]             r_q, r_d;
  logic [RW-1:0]             c_q, c_d;
  logic [MW-1:0]             buf_q, buf_d;
  logic [MW-1:0]             res_q, res_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic signed [DATA_W-1:0]    ea_s;
  logic signed [DATA_W-1:0]    eb_s;
  logic signed [2*DATA_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]     wide_s;
  logic                        in_range_s;
  logic [DATA_W-1:0]           elem_s;
  logic                        clamp_s;

  // Fetch element (r,c) of a packed matrix as a signed value.
  function automatic logic signed [DATA_W-1:0] elem_at(
    input logic [MW-1:0] m,
    input int            r,
    input int            c
  );
    elem_at = $signed(m[DATA_W*(c+DIM*r) +: DATA_W]);
  endfunction

  // Full-width value of the element currently addressed by (r_q, c_q).
  always_comb begin
    wide_s     = '0;
    prod_s     = '0;
    ea_s       = elem_at(a_q, int'(r_q), int'(c_q));
    eb_s       = elem_at(b_q, int'(r_q), int'(c_q));
    in_range_s = (int'(r_q) < int'(n_q)) && (int'(c_q) < int'(n_q));
    if (in_range_s) begin
      case (op_q)
        3'b000: wide_s = ACC_W'(ea_s) + ACC_W'(eb_s);
        3'b001: wide_s = ACC_W'(ea_s) - ACC_W'(eb_s);
        3'b010: begin
          for (int j = 0; j < DIM; j++) begin
            if (j < int'(n_q)) begin
              prod_s = elem_at(a_q, int'(r_q), j) * elem_at(b_q, j, int'(c_q));
              wide_s = wide_s + ACC_W'(prod_s);
            end else begin
              wide_s = wide_s;
            end
          end
        end
        3'b011: begin
          prod_s = ea_s * esc_q;
          wide_s = ACC_W'(prod_s);
        end
        3'b100: wide_s = ACC_W'(elem_at(a_q, int'(c_q), int'(r_q)));
        3'b101: wide_s = -ACC_W'(ea_s);
        default: wide_s = '0;
      endcase
    end else begin
      wide_s = '0;
    end
  end

`ifdef ULA_SEQ_SAT_EN
  logic sat_acc_q, sat_acc_d;
  logic sat_q, sat_d;

  // Clamp the full-width value into the DATA_W signed range.
  always_comb begin
    elem_s  = wide_s[DATA_W-1:0];
    clamp_s = 1'b0;
    if (wide_s > MAXV) begin
      elem_s  = MAXV[DATA_W-1:0];
      clamp_s = 1'b1;
    end else if (wide_s < MINV) begin
      elem_s  = MINV[DATA_W-1:0];
      clamp_s = 1'b1;
    end else begin
      elem_s  = wide_s[DATA_W-1:0];
      clamp_s = 1'b0;
    end
  end

  // Sticky saturation accumulator and its reported copy.
  always_comb begin
    sat_acc_d = sat_acc_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE:    if (start) sat_acc_d = 1'b0; else sat_acc_d = sat_acc_q;
      S_COMPUTE: sat_acc_d = sat_acc_q | clamp_s;
      S_DONE:    sat_d = sat_acc_q;
      default:   sat_acc_d = sat_acc_q;
    endcase
  end

  // Saturation state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      sat_acc_q <= sat_acc_d;
      sat_q     <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  logic unused_hi_s;

  // Wrap-around: keep the low DATA_W bits only.
  always_comb begin
    elem_s  = wide_s[DATA_W-1:0];
    clamp_s = 1'b0;
  end

  assign unused_hi_s = ^{wide_s[ACC_W-1:DATA_W], clamp_s, MAXV, MINV};
  assign sat         = 1'b0;
`endif

  // Sequencer: operand latch, element walk, buffer fill and result publish.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    esc_d   = esc_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    r_d     = r_q;
    c_d     = c_q;
    buf_d   = buf_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          n_d     = ((tamanho >= 8'd1) && (tamanho <= 8'(DIM))) ? tamanho : 8'(DIM);
          esc_d   = $signed(escalar);
          a_d     = matriz1;
          b_d     = matriz2;
          k_d     = '0;
          r_d     = '0;
          c_d     = '0;
          buf_d   = '0;
          busy_d  = 1'b1;
          state_d = S_COMPUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        buf_d[int'(k_q)*DATA_W +: DATA_W] = elem_s;
        if (k_q == KW'(NEL-1)) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
          // Row/column counters track k so no divide by DIM is needed.
          if (c_q == RW'(DIM-1)) begin
            c_d = '0;
            r_d = r_q + RW'(1);
          end else begin
            c_d = c_q + RW'(1);
          end
        end
      end
      S_DONE: begin
        res_d   = buf_q;
        done_d  = 1'b1;
        err_d   = op_q[2] & op_q[1];
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      n_q     <= 8'd0;
      esc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      buf_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      esc_q   <= esc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      r_q     <= r_d;
      c_q     <= c_d;
      buf_q   <= buf_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign resultado = res_q;

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq -- directed self-checking bench for ula_seq (DATA_W=8, DIM=5).
// Expectations follow ULA_SEQ_SAT_EN: saturating values when it is defined,
// wrap-around values otherwise.
// ---------------------------------------------------------------------------
module tb_ula_seq;

  typedef logic [199:0] mat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [7:0]  tamanho;
  logic [7:0]  escalar;
  mat_t        matriz1;
  mat_t        matriz2;
  logic        busy;
  logic        done;
  logic        sat;
  logic        err;
  mat_t        resultado;

  int checks = 0;
  int errors = 0;

`ifdef ULA_SEQ_SAT_EN
  localparam logic [7:0] ADD_EXP = 8'h7F;
  localparam logic       ADD_SAT = 1'b1;
  localparam logic [7:0] NEG_EXP = 8'h7F;
  localparam logic       NEG_SAT = 1'b1;
`else
  localparam logic [7:0] ADD_EXP = 8'h96;
  localparam logic       ADD_SAT = 1'b0;
  localparam logic [7:0] NEG_EXP = 8'h80;
  localparam logic       NEG_SAT = 1'b0;
`endif

  ula_seq #(.DATA_W(8), .DIM(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .tamanho(tamanho),
    .escalar(escalar), .matriz1(matriz1), .matriz2(matriz2), .busy(busy),
    .done(done), .sat(sat), .err(err), .resultado(resultado)
  );

  always #5 clk = ~clk;

  function automatic mat_t fill(input logic [7:0] v);
    mat_t m;
    for (int i = 0; i < 25; i++) m[8*i +: 8] = v;
    return m;
  endfunction

  function automatic mat_t idx_mat();
    mat_t m;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) m[8*(c+5*r) +: 8] = 8'(5*r + c);
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int r = 0; r < 5; r++) m[8*(r+5*r) +: 8] = 8'd1;
    return m;
  endfunction

  // Issue one operation and wait (bounded) for done; lat = edges after start edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] tam, input logic [7:0] esc,
                        input mat_t a, input mat_t b, output int lat, output logic busy1);
    @(negedge clk);
    opcode = op; tamanho = tam; escalar = esc; matriz1 = a; matriz2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; opcode = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    checks++; if ({busy, done, sat, err} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, sat, err}); end
    checks++; if (resultado !== '0)
      begin errors++; $display("FAIL reset_result: got %h want 0", resultado); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_add();
    int lat; logic b1;
    run_op(3'b000, 8'd5, 8'd0, fill(8'd100), fill(8'd50), lat, b1);
    checks++; if (lat !== 26) begin errors++; $display("FAIL add_latency: got %0d want 26", lat); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", b1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    checks++; if (sat !== ADD_SAT) begin errors++; $display("FAIL add_sat: got %b want %b", sat, ADD_SAT); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", err); end
    for (int i = 0; i < 25; i++) begin
      checks++; if (resultado[8*i +: 8] !== ADD_EXP)
        begin errors++; $display("FAIL add_elem%0d: got %h want %h", i, resultado[8*i +: 8], ADD_EXP); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_multiply();
    int lat; logic b1;
    run_op(3'b010, 8'd5, 8'd0, ident(), idx_mat(), lat, b1);
    checks++; if (lat !== 26) begin errors++; $display("FAIL mul_latency: got %0d want 26", lat); end
    checks++; if (resultado !== idx_mat())
      begin errors++; $display("FAIL mul_result: got %h want %h", resultado, idx_mat()); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL mul_sat: got %b want 0", sat); end
  endtask

  task automatic test_transpose();
    int lat; logic b1; logic [7:0] exp_v;
    run_op(3'b100, 8'd3, 8'd0, idx_mat(), '0, lat, b1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        exp_v = (r < 3 && c < 3) ? 8'(5*c + r) : 8'h00;
        checks++; if (resultado[8*(c+5*r) +: 8] !== exp_v)
          begin errors++; $display("FAIL tr_elem_%0d_%0d: got %h want %h", r, c, resultado[8*(c+5*r) +: 8], exp_v); end
      end
  endtask

  task automatic test_scalar();
    int lat; logic b1; logic [7:0] exp_v;
    run_op(3'b011, 8'd2, 8'hFB, fill(8'd3), '0, lat, b1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        exp_v = (r < 2 && c < 2) ? 8'hF1 : 8'h00;
        checks++; if (resultado[8*(c+5*r) +: 8] !== exp_v)
          begin errors++; $display("FAIL scal_elem_%0d_%0d: got %h want %h", r, c, resultado[8*(c+5*r) +: 8], exp_v); end
      end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL scal_sat: got %b want 0", sat); end
  endtask

  task automatic test_negate();
    int lat; logic b1;
    run_op(3'b101, 8'd6, 8'd0, fill(8'h80), '0, lat, b1);
    checks++; if (resultado !== fill(NEG_EXP))
      begin errors++; $display("FAIL neg_result: got %h want %h", resultado, fill(NEG_EXP)); end
    checks++; if (sat !== NEG_SAT) begin errors++; $display("FAIL neg_sat: got %b want %b", sat, NEG_SAT); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    opcode = 3'b001; tamanho = 8'd5; matriz1 = fill(8'd9); matriz2 = fill(8'd1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 9; e++) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00)
      begin errors++; $display("FAIL rstmid_flags: got %b want 00", {busy, done}); end
    checks++; if (resultado !== '0)
      begin errors++; $display("FAIL rstmid_result: got %h want 0", resultado); end
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int ndone; int first; mat_t cap;
    @(negedge clk);
    opcode = 3'b000; tamanho = 8'd5; matriz1 = fill(8'd1); matriz2 = fill(8'd2); start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = -1; cap = '0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e == 5 || e == 15 || e == 26) begin
        start = 1'b1; opcode = 3'b101; matriz1 = fill(8'd50);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = e; cap = resultado; end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
    checks++; if (first !== 26) begin errors++; $display("FAIL b2b_latency: got %0d want 26", first); end
    checks++; if (cap !== fill(8'd3))
      begin errors++; $display("FAIL b2b_result: got %h want %h", cap, fill(8'd3)); end
    checks++; if (resultado !== fill(8'd3))
      begin errors++; $display("FAIL b2b_hold: got %h want %h", resultado, fill(8'd3)); end
  endtask

  task automatic test_reserved();
    int lat; logic b1;
    run_op(3'b111, 8'd5, 8'd7, idx_mat(), fill(8'd9), lat, b1);
    checks++; if (lat !== 26) begin errors++; $display("FAIL rsv_latency: got %0d want 26", lat); end
    checks++; if (resultado !== '0) begin errors++; $display("FAIL rsv_result: got %h want 0", resultado); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b want 1", err); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL rsv_sat: got %b want 0", sat); end
  endtask

  task automatic test_sub_tam0();
    int lat; logic b1;
    run_op(3'b001, 8'd0, 8'd0, fill(8'd10), fill(8'd3), lat, b1);
    checks++; if (resultado !== fill(8'd7))
      begin errors++; $display("FAIL sub_result: got %h want %h", resultado, fill(8'd7)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sub_err_clear: got %b want 0", err); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 3'b000; tamanho = 8'd0; escalar = 8'd0;
    matriz1 = '0; matriz2 = '0;
    test_reset();
    test_add();
    test_multiply();
    test_transpose();
    test_scalar();
    test_negate();
    test_reset_mid();
    test_back_to_back();
    test_reserved();
    test_sub_tam0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
